// File: rtl/fp_ctrl_pkg.sv
// rtl/fp_ctrl_pkg.sv - shared constants and tag type for the FP add/sub arbiter
package fp_ctrl_pkg;
  localparam int DATA_W          = 32;
  localparam int ADD_LATENCY_DEF = 6;
  localparam int TAG_ID_W        = 3;   // wide enough for up to 8 requesters
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;
endpackage

// File: rtl/fp_addsub_arbiter_rr.sv
// rtl/fp_addsub_arbiter_rr.sv - combinational round-robin grant with registered pointer
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic           advance,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id
);
  logic [IDW-1:0] ptr;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IDW-1:0] off;
  logic [IDW:0]   sum;
  logic           found;

  // Rotate requests so bit 0 is the pointer position; the lowest set bit wins.
  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[N-1:0];
    off   = '0;
    found = 1'b0;
    for (int k = N-1; k >= 0; k--) begin
      if (rot[k]) begin
        off   = IDW'(k);
        found = 1'b1;
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IDW+1)'(N)) sum = sum - (IDW+1)'(N);
    gnt_id = sum[IDW-1:0];
    gnt    = found ? (N'(1) << gnt_id) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else if (advance) ptr <= (gnt_id == IDW'(N-1)) ? '0 : gnt_id + 1'b1;
  end
endmodule

// File: rtl/fp_addsub_arbiter.sv
// rtl/fp_addsub_arbiter.sv - shares one pipelined FP adder among NUM_REQ requesters
module fp_addsub_arbiter
  import fp_ctrl_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int ADD_LATENCY = ADD_LATENCY_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]        req_a,
  input  logic [NUM_REQ*DATA_W-1:0]        req_b,
  input  logic [NUM_REQ-1:0]               req_op,
  input  logic                             hold,
  output logic [DATA_W-1:0]                add_a,
  output logic [DATA_W-1:0]                add_b,
  output logic                             add_op,
  output logic                             add_ce,
  input  logic [DATA_W-1:0]                add_result,
  output logic                             resp_valid,
  output logic [ID_W-1:0]                  resp_id,
  output logic [DATA_W-1:0]                resp_data,
  output logic [NUM_REQ*DATA_W-1:0]        last_result,
  output logic [$clog2(ADD_LATENCY+2)-1:0] inflight
);
  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     gnt_id;
  logic                accept;
  logic                iss_valid;
  logic [TAG_ID_W-1:0] iss_id;
  tag_t                tag [ADD_LATENCY];
  logic                resp_fire;
  logic [ID_W-1:0]     last_id;

  assign add_ce    = !hold;
  assign req_ready = (hold || rst) ? '0 : gnt;
  assign accept    = |(req_valid & req_ready);

  rr_arbiter #(.N(NUM_REQ), .IDW(ID_W)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (accept),
    .gnt     (gnt),
    .gnt_id  (gnt_id)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      iss_valid <= 1'b0;
      iss_id    <= '0;
      add_a     <= '0;
      add_b     <= '0;
      add_op    <= 1'b0;
    end else if (add_ce) begin
      iss_valid <= accept;
      iss_id    <= TAG_ID_W'(gnt_id);
      if (accept) begin
        add_a  <= req_a[gnt_id*DATA_W +: DATA_W];
        add_b  <= req_b[gnt_id*DATA_W +: DATA_W];
        add_op <= req_op[gnt_id];
      end
    end
  end

  // Tag stages advance in lockstep with the adder so the last stage lines up with add_result.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ADD_LATENCY; i++) tag[i] <= '0;
    end else if (add_ce) begin
      tag[0].valid <= iss_valid;
      tag[0].id    <= iss_id;
      for (int i = 1; i < ADD_LATENCY; i++) tag[i] <= tag[i-1];
    end
  end

  assign resp_fire = add_ce && tag[ADD_LATENCY-1].valid;
  assign last_id   = ID_W'(tag[ADD_LATENCY-1].id);

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid  <= 1'b0;
      resp_id     <= '0;
      resp_data   <= '0;
      last_result <= '0;
    end else begin
      resp_valid <= resp_fire;
      if (resp_fire) begin
        resp_id   <= last_id;
        resp_data <= add_result;
        last_result[last_id*DATA_W +: DATA_W] <= add_result;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) inflight <= '0;
    else begin
      case ({accept, resp_fire})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end
endmodule

// File: doc/fp_addsub_arbiter.md
Name: fp_addsub_arbiter

Overview:
- Shares one pipelined single-precision FP adder/subtractor among NUM_REQ requesters, such as the Jacobi cluster row engines.
- Round-robin arbitration; accepts at most one operation per cycle.
- Tracks in-flight operations with a tag pipeline matched to the adder latency.
- Routes each result back with the requester ID, and keeps a per-requester last-result hold register.
- Sits between the requester engines and the adder wrapper (IEEE-to-internal input conversion, adder core, output conversion).

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width, equal to clog2(NUM_REQ).
- ADD_LATENCY, 6, cycles from add_a/add_b/add_op presented with add_ce=1 to the matching add_result; counts enabled cycles only.
- DATA_W, 32, IEEE-754 single-precision word width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester operation request
- req_ready  out  NUM_REQ  one-hot grant; operation accepted when req_valid[i] and req_ready[i] are both high
- req_a  in  NUM_REQ*DATA_W  operand A, requester i at bits [i*32 +: 32]
- req_b  in  NUM_REQ*DATA_W  operand B, same packing as req_a
- req_op  in  NUM_REQ  0 = A+B, 1 = A-B
- hold  in  1  freeze: stops issue and adder advance
- add_a  out  DATA_W  operand A to the adder wrapper
- add_b  out  DATA_W  operand B to the adder wrapper
- add_op  out  1  op select to the adder wrapper
- add_ce  out  1  adder clock enable
- add_result  in  DATA_W  adder wrapper output
- resp_valid  out  1  result valid, one-cycle pulse
- resp_id  out  ID_W  requester that owns the result
- resp_data  out  DATA_W  result value
- last_result  out  NUM_REQ*DATA_W  most recent result per requester
- inflight  out  clog2(ADD_LATENCY+2)  number of operations in flight

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - rr_ptr=0; tag valids=0; issue register invalid.
  - add_a=0, add_b=0, add_op=0.
  - resp_valid=0, resp_id=0, resp_data=0, last_result=0, inflight=0.
  - req_ready=0 while rst is high.
  - Reset mid-operation discards all in-flight tags; no response is ever emitted for them.
- Grant (combinational):
  - Among the req_valid bits, pick the first set bit at or after rr_ptr, wrapping modulo NUM_REQ.
  - req_ready = one-hot of that bit, qualified by !hold && !rst.
  - No request pending: req_ready=0.
- Accept:
  - Capture the winner's operands, op and ID into the issue register; rr_ptr <= winner+1, wrapping to 0 after NUM_REQ-1.
  - rr_ptr is unchanged when nothing is accepted.
- Issue:
  - Issue register drives add_a/add_b/add_op the cycle after accept.
  - add_ce = !hold.
  - The issue register's valid+ID enters tag stage 0 on each clk edge with add_ce=1.
- Tag pipeline: ADD_LATENCY stages of {valid, id}.
  - Shifts only when add_ce=1; when hold=1, every stage and the issue register keep their value.
- Response:
  - When the last tag stage is valid and add_ce=1: resp_valid=1, resp_id=tag id, resp_data=add_result, all registered.
  - The same edge writes last_result[id] <= add_result.
  - Otherwise resp_valid=0, and resp_data/resp_id keep their last value.
- Latency: accept to resp_valid is ADD_LATENCY+1 enabled cycles (7 at defaults). Hold cycles extend it one-for-one.
- Throughput: one operation per cycle sustained, no bubbles.
- inflight:
  - +1 on accept, -1 on response.
  - Both in the same cycle leave it unchanged.
  - Never exceeds ADD_LATENCY+1.
- hold and a request asserted together: no grant, operands stay pending. The requester keeps req_valid and its operands stable until it sees req_ready.
- Single requester asserting continuously: granted every cycle.
- All requesters asserting: grants rotate 0,1,2,3,0,...

Decomposition:
- Shared package fp_ctrl_pkg:
  - DATA_W, default ADD_LATENCY, the op encodings (OP_ADD=0, OP_SUB=1);
  - tag typedef {valid, id}.
- Sub-module rr_arbiter: combinational round-robin with a registered pointer.
  - Ports: clk, rst, req, advance → gnt one-hot, gnt_id.
  - The tag pipeline stays inline.

Test Plan:
- Reset with req_valid=4'b1111, rst=1 → req_ready=0, resp_valid=0, inflight=0. First grant after rst drops goes to requester 0.
- Requester 2 only, A=0x3F800000, B=0x40000000, op=0 (add) → response 7 cycles after accept: resp_valid=1, resp_id=2, resp_data=0x40400000, last_result[2] updated.
- Requester 1, A=0x40A00000, B=0x40400000, op=1 (subtract) → resp_data=0x40000000, resp_id=1.
- All four requesting for 8 cycles → grant order 0,1,2,3,0,1,2,3; responses arrive in that order on consecutive cycles; inflight peaks at 7.
- hold=1 for 3 cycles with 4 operations in flight → no grants, no resp_valid during hold; responses resume afterwards in the same order, each delayed by exactly 3 cycles.
- rst pulsed with 5 operations in flight → no resp_valid afterwards, inflight=0, last_result all zero.
